// File: rtl/mac_multiplex_ctrl.sv
// Job sequencer for a precision-configurable MAC: reconfigures on mode change,
// clears the accumulator, streams operands, drains the MAC pipeline and hands off z.
module mac_multiplex_ctrl #(
  parameter int W_WIDTH         = 8,
  parameter int A_WIDTH         = 8,
  parameter int PLUS_WIDTH      = 4,
  parameter int CONFIG_AW_WIDTH = 2,
  parameter int LEN_WIDTH       = 8,
  parameter int CFG_CYCLES      = 2,
  parameter int MAC_LATENCY     = 2,
  localparam int Z_WIDTH = W_WIDTH + A_WIDTH + (2**CONFIG_AW_WIDTH) * PLUS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CONFIG_AW_WIDTH-1:0] cmd_mode,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [W_WIDTH-1:0]         op_w,
  input  logic [A_WIDTH-1:0]         op_a,
  output logic                       mac_rst,
  output logic                       mac_accu_rst,
  output logic [CONFIG_AW_WIDTH-1:0] mac_config_aw,
  output logic [W_WIDTH-1:0]         mac_w,
  output logic [A_WIDTH-1:0]         mac_a,
  input  logic [Z_WIDTH-1:0]         mac_z,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [Z_WIDTH-1:0]         res_z,
  output logic                       res_err
);

  localparam int CFG_CNT_W   = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;
  localparam int DRAIN_CNT_W = (MAC_LATENCY > 0) ? $clog2(MAC_LATENCY + 1) : 1;
  localparam logic [CFG_CNT_W-1:0]   CFG_LAST   = CFG_CNT_W'(CFG_CYCLES - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(MAC_LATENCY);

  typedef enum logic [2:0] {IDLE, CFG, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t                   state;
  logic                     configured;
  logic [LEN_WIDTH-1:0]     remaining;
  logic [CFG_CNT_W-1:0]     cfg_cnt;
  logic [DRAIN_CNT_W-1:0]   drain_cnt;
  logic                     mode_legal;

  // Legal modes split the operands into mode+1 lanes, so mode+1 must be a power of two.
  assign mode_legal = ((cmd_mode & (cmd_mode + CONFIG_AW_WIDTH'(1))) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      configured    <= 1'b0;
      remaining     <= '0;
      cfg_cnt       <= '0;
      drain_cnt     <= '0;
      cmd_ready     <= 1'b1;
      op_ready      <= 1'b0;
      res_valid     <= 1'b0;
      res_err       <= 1'b0;
      res_z         <= '0;
      mac_rst       <= 1'b1;
      mac_accu_rst  <= 1'b1;
      mac_config_aw <= '0;
      mac_w         <= '0;
      mac_a         <= '0;
    end else begin
      mac_w <= '0;
      mac_a <= '0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            remaining <= cmd_len;
            cmd_ready <= 1'b0;
            if (!mode_legal) begin
              state        <= DONE;
              res_valid    <= 1'b1;
              res_err      <= 1'b1;
              res_z        <= '0;
              mac_accu_rst <= 1'b0;
            end else if (!configured || (cmd_mode != mac_config_aw)) begin
              state         <= CFG;
              mac_config_aw <= cmd_mode;
              mac_rst       <= 1'b1;
              cfg_cnt       <= '0;
            end else begin
              state <= CLEAR;
            end
          end
        end

        CFG: begin
          if (cfg_cnt == CFG_LAST) begin
            state      <= CLEAR;
            mac_rst    <= 1'b0;
            configured <= 1'b1;
          end else begin
            cfg_cnt <= cfg_cnt + CFG_CNT_W'(1);
          end
        end

        CLEAR: begin
          mac_accu_rst <= 1'b0;
          if (remaining == '0) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            state    <= RUN;
            op_ready <= 1'b1;
          end
        end

        RUN: begin
          if (op_valid && op_ready) begin
            mac_w     <= op_w;
            mac_a     <= op_a;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state     <= DRAIN;
              op_ready  <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end

        // The final operand needs MAC_LATENCY+1 cycles to show up on mac_z.
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_z     <= mac_z;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
          end
        end

        DONE: begin
          if (res_ready) begin
            state        <= IDLE;
            res_valid    <= 1'b0;
            cmd_ready    <= 1'b1;
            mac_accu_rst <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_multiplex_ctrl.sv
// Self-checking bench for mac_multiplex_ctrl: a behavioural lane-split MAC drives mac_z,
// and each job result is compared against per-lane sums computed straight from the operands.
module tb_mac_multiplex_ctrl;

  localparam int CFG_CYCLES  = 2;
  localparam int MAC_LATENCY = 2;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [7:0]  cmd_len;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_w;
  logic [7:0]  op_a;
  logic        mac_rst;
  logic        mac_accu_rst;
  logic [1:0]  mac_config_aw;
  logic [7:0]  mac_w;
  logic [7:0]  mac_a;
  logic [31:0] mac_z;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_z;
  logic        res_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  job_w[$];
  logic [7:0]  job_a[$];
  int          gap;
  int          hold;
  bit          model_cfg;
  logic [1:0]  model_mode;
  logic [31:0] last_z;

  mac_multiplex_ctrl #(
    .CFG_CYCLES  (CFG_CYCLES),
    .MAC_LATENCY (MAC_LATENCY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_len       (cmd_len),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_w          (op_w),
    .op_a          (op_a),
    .mac_rst       (mac_rst),
    .mac_accu_rst  (mac_accu_rst),
    .mac_config_aw (mac_config_aw),
    .mac_w         (mac_w),
    .mac_a         (mac_a),
    .mac_z         (mac_z),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_z         (res_z),
    .res_err       (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lanes_of(input logic [1:0] mode);
    if (mode == 2'd3) return 4;
    if (mode == 2'd1) return 2;
    return 1;
  endfunction

  // Signed weight slice times unsigned activation slice for one lane.
  function automatic longint sub_prod(input logic [1:0] mode, input logic [7:0] w,
                                      input logic [7:0] a, input int lane);
    int bw;
    longint sw, ua;
    bw = 8 / lanes_of(mode);
    ua = longint'(a >> (lane * bw)) & ((longint'(1) << bw) - 1);
    sw = longint'(w >> (lane * bw)) & ((longint'(1) << bw) - 1);
    if (sw >= (longint'(1) << (bw - 1))) sw = sw - (longint'(1) << bw);
    return sw * ua;
  endfunction

  function automatic logic [31:0] mac_step(input logic [31:0] acc, input logic [1:0] mode,
                                           input logic [7:0] w, input logic [7:0] a);
    int n, lw;
    longint mask, lane;
    logic [31:0] r;
    n = lanes_of(mode);
    lw = 32 / n;
    mask = (longint'(1) << lw) - 1;
    r = '0;
    for (int i = 0; i < n; i++) begin
      lane = (longint'(acc) >> (i * lw)) & mask;
      lane = (lane + sub_prod(mode, w, a, i)) & mask;
      r = r | 32'(lane << (i * lw));
    end
    return r;
  endfunction

  // Reference result: whole-job per-lane sums, wrapped to the lane width and packed.
  function automatic logic [31:0] expected_z(input logic [1:0] mode);
    int n, lw;
    longint mask, sum;
    logic [31:0] r;
    r = '0;
    if (mode == 2'd2) return r;
    n = lanes_of(mode);
    lw = 32 / n;
    mask = (longint'(1) << lw) - 1;
    for (int i = 0; i < n; i++) begin
      sum = 0;
      for (int k = 0; k < job_w.size(); k++) sum = sum + sub_prod(mode, job_w[k], job_a[k], i);
      r = r | 32'((sum & mask) << (i * lw));
    end
    return r;
  endfunction

  // Behavioural MAC: operand seen in cycle t is reflected on mac_z in cycle t+MAC_LATENCY.
  logic [31:0] mac_acc = '0;
  logic [31:0] mac_z_r = '0;
  always @(posedge clk) begin
    if (mac_rst || mac_accu_rst) mac_acc <= '0;
    else mac_acc <= mac_step(mac_acc, mac_config_aw, mac_w, mac_a);
    mac_z_r <= mac_acc;
  end
  assign mac_z = mac_z_r;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] mode, input int len, output int hs);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_len   = len[7:0];
    hs = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'($urandom);
    cmd_len   = 8'($urandom);
  endtask

  // Runs one whole job from the job_w/job_a queues, inserting gap bubbles and holding res_ready low.
  task automatic applyStimulus(input logic [1:0] mode, input int len);
    bit legal, need_cfg, ready_seen;
    logic [31:0] exp_z;
    logic [1:0] first_aw;
    logic first_accu;
    int idx, gapcnt, t, limit, rst_cycles, cmd_hs, last_hs, res_cyc;
    legal    = (mode != 2'd2);
    need_cfg = legal && (!model_cfg || mode != model_mode);
    exp_z    = expected_z(mode);
    issue_cmd(mode, len, cmd_hs);
    first_aw   = mac_config_aw;
    first_accu = mac_accu_rst;
    idx = 0; gapcnt = 0; rst_cycles = 0; ready_seen = 0; last_hs = -1; t = 0;
    limit = len * (gap + 1) + 40;
    while (res_valid !== 1'b1 && t < limit) begin
      if (mac_rst === 1'b1) rst_cycles++;
      if (op_ready === 1'b1) begin
        ready_seen = 1;
        if (idx < job_w.size() && gapcnt == 0) begin
          op_valid = 1'b1;
          op_w = job_w[idx];
          op_a = job_a[idx];
          last_hs = cyc;
          idx++;
          gapcnt = gap;
        end else begin
          op_valid = 1'b0;
          op_w = 8'($urandom);
          op_a = 8'($urandom);
          if (gapcnt > 0) gapcnt--;
        end
      end else begin
        op_valid = 1'($urandom_range(0, 1));
        op_w = 8'($urandom);
        op_a = 8'($urandom);
      end
      @(posedge clk); #1;
      t++;
    end
    op_valid = 1'b0;
    res_cyc = cyc;
    checkOutput("res_valid_seen", 64'(res_valid), 64'(1));
    checkOutput("ops_accepted", 64'(idx), 64'(legal ? len : 0));
    if (legal) begin
      checkOutput("cfg_mac_rst_cycles", 64'(rst_cycles), 64'(need_cfg ? CFG_CYCLES : 0));
      checkOutput("cfg_aw_after_cmd", 64'(first_aw), 64'(mode));
      checkOutput("accu_rst_after_cmd", 64'(first_accu), 64'(1));
      if (len > 0)
        checkOutput("latency_last_op", 64'(res_cyc - last_hs), 64'(MAC_LATENCY + 2));
      else
        checkOutput("latency_len0", 64'(res_cyc - cmd_hs),
                    64'((need_cfg ? CFG_CYCLES : 0) + MAC_LATENCY + 3));
    end else begin
      checkOutput("illegal_op_ready", 64'(ready_seen), 64'(0));
      checkOutput("illegal_latency", 64'(res_cyc - cmd_hs), 64'(1));
      checkOutput("illegal_cfg_aw", 64'(mac_config_aw), 64'(model_mode));
    end
    last_z = res_z;
    checkOutput("res_z", 64'(res_z), 64'(exp_z));
    checkOutput("res_err", 64'(res_err), 64'(!legal));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checkOutput("hold_res_valid", 64'(res_valid), 64'(1));
      checkOutput("hold_res_z", 64'(res_z), 64'(exp_z));
      checkOutput("hold_res_err", 64'(res_err), 64'(!legal));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput("res_valid_drop", 64'(res_valid), 64'(0));
    checkOutput("cmd_ready_back", 64'(cmd_ready), 64'(1));
    if (legal) begin
      model_cfg  = 1'b1;
      model_mode = mode;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no completion, required summary before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs, n, t;
    bit seen;
    logic [1:0] md;
    int ln;

    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_len = '0;
    op_valid = 1'b0; op_w = '0; op_a = '0; res_ready = 1'b0;
    gap = 0; hold = 0; model_cfg = 1'b0; model_mode = '0; last_z = '0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] checking reset values");
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("rst_op_ready", 64'(op_ready), 64'(0));
    checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
    checkOutput("rst_res_err", 64'(res_err), 64'(0));
    checkOutput("rst_res_z", 64'(res_z), 64'(0));
    checkOutput("rst_mac_rst", 64'(mac_rst), 64'(1));
    checkOutput("rst_mac_accu_rst", 64'(mac_accu_rst), 64'(1));
    checkOutput("rst_mac_config_aw", 64'(mac_config_aw), 64'(0));
    checkOutput("rst_mac_w", 64'(mac_w), 64'(0));
    checkOutput("rst_mac_a", 64'(mac_a), 64'(0));
    rst = 1'b0;
    op_valid = 1'b1; op_w = 8'h55; op_a = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    op_valid = 1'b0;
    checkOutput("idle_mac_rst_held", 64'(mac_rst), 64'(1));
    checkOutput("idle_op_ready", 64'(op_ready), 64'(0));
    checkOutput("idle_mac_w_ignores_op", 64'(mac_w), 64'(0));

    $display("[TB] first job after reset, mode 0");
    job_w = '{8'hFF, 8'h03, 8'h80};
    job_a = '{8'h02, 8'h04, 8'h01};
    applyStimulus(2'd0, 3);
    checkOutput("first_job_const", 64'(last_z), 64'(32'hFFFFFF8A));

    $display("[TB] repeat mode 0 then switch to mode 3");
    job_w = '{8'h7F, 8'h81};
    job_a = '{8'hFF, 8'h10};
    applyStimulus(2'd0, 2);
    job_w = '{8'b01_10_11_00, 8'b11_11_01_10, 8'b10_01_00_11, 8'hFF};
    job_a = '{8'b11_01_10_11, 8'b10_11_11_01, 8'hFF, 8'hA5};
    applyStimulus(2'd3, 4);

    $display("[TB] bubbles and result backpressure");
    job_w = '{8'h12, 8'hF3, 8'h9C, 8'h44};
    job_a = '{8'hC8, 8'h27, 8'h5E, 8'hFF};
    gap = 0; hold = 0;
    applyStimulus(2'd0, 4);
    gap = 3; hold = 5;
    applyStimulus(2'd0, 4);
    checkOutput("bubble_z_const", 64'(last_z), 64'(expected_z(2'd0)));
    gap = 0; hold = 0;

    $display("[TB] boundary jobs");
    job_w.delete(); job_a.delete();
    applyStimulus(2'd0, 0);
    for (int i = 0; i < 255; i++) begin
      job_w.push_back(8'd1);
      job_a.push_back(8'd1);
    end
    applyStimulus(2'd0, 255);
    checkOutput("len255_const", 64'(last_z), 64'(255));

    $display("[TB] illegal mode");
    job_w.delete(); job_a.delete();
    hold = 2;
    applyStimulus(2'd2, 5);
    hold = 0;

    $display("[TB] reset in the middle of a mode 1 job");
    issue_cmd(2'd1, 6, hs);
    n = 0; t = 0;
    while (n < 3 && t < 40) begin
      if (op_ready === 1'b1) begin
        op_valid = 1'b1; op_w = 8'($urandom); op_a = 8'($urandom);
        n++;
      end else begin
        op_valid = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    checkOutput("midrun_ops_fed", 64'(n), 64'(3));
    checkOutput("midrun_in_run", 64'(op_ready), 64'(1));
    op_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0;
    model_cfg = 1'b0; model_mode = '0;
    checkOutput("midrun_cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("midrun_op_ready", 64'(op_ready), 64'(0));
    checkOutput("midrun_res_valid", 64'(res_valid), 64'(0));
    checkOutput("midrun_mac_rst", 64'(mac_rst), 64'(1));
    checkOutput("midrun_config_aw", 64'(mac_config_aw), 64'(0));
    checkOutput("midrun_mac_w", 64'(mac_w), 64'(0));
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0) seen = 1;
    end
    checkOutput("midrun_no_result", 64'(seen), 64'(0));
    job_w = '{8'h9A, 8'h3C, 8'hE7};
    job_a = '{8'h5F, 8'hA1, 8'h0E};
    applyStimulus(2'd1, 3);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 16; j++) begin
      n  = $urandom_range(0, 7);
      md = (n == 7) ? 2'd2 : ((n < 3) ? 2'd0 : ((n < 5) ? 2'd1 : 2'd3));
      ln = (j == 5) ? 0 : $urandom_range(1, 20);
      job_w.delete(); job_a.delete();
      if (md != 2'd2) begin
        for (int k = 0; k < ln; k++) begin
          job_w.push_back(8'($urandom));
          job_a.push_back(8'($urandom));
        end
      end
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      applyStimulus(md, ln);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
